serial_cla_adder: RTL

//  Multi-cycle WIDTH-bit adder that streams operands one nibble per cycle

---
 rtl/serial_cla_adder_if.sv | 39 +++
 rtl/serial_cla_adder.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/serial_cla_adder_if.sv
// serial_cla_adder_if: operand/result handshake bundle for serial_cla_adder.
// The slave modport is the adder side, the master modport is the producer/consumer side.
// Optional build macro OVERFLOW_EN adds the signed-overflow flag (ovf).
interface serial_cla_adder_if #(
   parameter int WIDTH = 16
);
   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             cin;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] sum;
   logic             cout;
`ifdef OVERFLOW_EN
   logic             ovf;

   modport slave (
      input  in_valid, a, b, cin, out_ready,
      output in_ready, out_valid, sum, cout, ovf
   );

   modport master (
      output in_valid, a, b, cin, out_ready,
      input  in_ready, out_valid, sum, cout, ovf
   );
`else
   modport slave (
      input  in_valid, a, b, cin, out_ready,
      output in_ready, out_valid, sum, cout
   );

   modport master (
      output in_valid, a, b, cin, out_ready,
      input  in_ready, out_valid, sum, cout
   );
`endif
endinterface

// File: rtl/serial_cla_adder.sv
// serial_cla_adder: WIDTH-bit adder that walks the operands one nibble per
// cycle through a 4-bit carry-lookahead slice, carrying between cycles.
// Accept in IDLE, NIB cycles of RUN, result presented in DONE until taken.
// Optional build macro OVERFLOW_EN: captures operand MSBs and drives ovf.
module serial_cla_adder #(
   parameter int WIDTH = 16
) (
   input logic               clk,
   input logic               rst,
   serial_cla_adder_if.slave bus
);

   localparam int NIB   = WIDTH / 4;
   localparam int IDX_W = (NIB > 1) ? $clog2(NIB) : 1;
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NIB - 1);
   localparam logic [IDX_W-1:0] IDX_ONE  = IDX_W'(1);
   localparam logic [IDX_W-1:0] IDX_ZERO = IDX_W'(0);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   // 4-bit carry-lookahead slice; returns {carry_out, sum[3:0]}.
   // Carries are flattened from the generate/propagate terms so no carry
   // ripples inside the slice.
   function automatic logic [4:0] cla4(
      input logic [3:0] a4,
      input logic [3:0] b4,
      input logic       c0
   );
      logic [3:0] p_s;
      logic [3:0] g_s;
      logic [4:0] c_s;
      p_s    = a4 ^ b4;
      g_s    = a4 & b4;
      c_s[0] = c0;
      c_s[1] = g_s[0] | (p_s[0] & c0);
      c_s[2] = g_s[1] | (p_s[1] & g_s[0]) | (p_s[1] & p_s[0] & c0);
      c_s[3] = g_s[2] | (p_s[2] & g_s[1]) | (p_s[2] & p_s[1] & g_s[0])
             | (p_s[2] & p_s[1] & p_s[0] & c0);
      c_s[4] = g_s[3] | (p_s[3] & g_s[2]) | (p_s[3] & p_s[2] & g_s[1])
             | (p_s[3] & p_s[2] & p_s[1] & g_s[0])
             | (p_s[3] & p_s[2] & p_s[1] & p_s[0] & c0);
      return {c_s[4], p_s ^ c_s[3:0]};
   endfunction

   state_t           state_r;
   state_t           state_nx_s;
   logic             in_ready_r;
   logic             in_ready_nx_s;
   logic             out_valid_r;
   logic             out_valid_nx_s;

   logic [WIDTH-1:0] a_r;
   logic [WIDTH-1:0] b_r;
   logic [WIDTH-1:0] acc_r;
   logic             carry_r;
   logic [IDX_W-1:0] idx_r;
   logic [WIDTH-1:0] sum_r;
   logic             cout_r;

   logic [4:0]       slice_s;
   logic [WIDTH+3:0] shift_s;
   logic [WIDTH-1:0] acc_nx_s;
   logic             last_s;
   logic             accept_s;

`ifdef OVERFLOW_EN
   logic             a_msb_r;
   logic             b_msb_r;
   logic             ovf_r;
`endif

   // Slice datapath: low nibbles plus running carry; new nibble enters the
   // accumulator from the MSB end (the concat form also covers WIDTH=4).
   assign slice_s  = cla4(a_r[3:0], b_r[3:0], carry_r);
   assign shift_s  = {slice_s[3:0], acc_r};
   assign acc_nx_s = shift_s[WIDTH+3:4];
   assign last_s   = (idx_r == LAST_IDX);
   assign accept_s = (state_r == ST_IDLE) & bus.in_valid;

   // State register with registered handshake outputs decoded from next state.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_r     <= ST_IDLE;
         in_ready_r  <= 1'b1;
         out_valid_r <= 1'b0;
      end else begin
         state_r     <= state_nx_s;
         in_ready_r  <= in_ready_nx_s;
         out_valid_r <= out_valid_nx_s;
      end
   end

   // Next-state logic: IDLE -> RUN on accept, RUN -> DONE after last nibble,
   // DONE -> IDLE when the consumer takes the result.
   always_comb begin
      state_nx_s = state_r;
      case (state_r)
         ST_IDLE: begin
            if (bus.in_valid) begin
               state_nx_s = ST_RUN;
            end else begin
               state_nx_s = ST_IDLE;
            end
         end
         ST_RUN: begin
            if (last_s) begin
               state_nx_s = ST_DONE;
            end else begin
               state_nx_s = ST_RUN;
            end
         end
         ST_DONE: begin
            if (bus.out_ready) begin
               state_nx_s = ST_IDLE;
            end else begin
               state_nx_s = ST_DONE;
            end
         end
         default: begin
            state_nx_s = ST_IDLE;
         end
      endcase
   end

   // Output decode of the upcoming state so in_ready/out_valid come from flops.
   always_comb begin
      in_ready_nx_s  = 1'b0;
      out_valid_nx_s = 1'b0;
      case (state_nx_s)
         ST_IDLE: begin
            in_ready_nx_s = 1'b1;
         end
         ST_RUN: begin
            in_ready_nx_s  = 1'b0;
            out_valid_nx_s = 1'b0;
         end
         ST_DONE: begin
            out_valid_nx_s = 1'b1;
         end
         default: begin
            in_ready_nx_s  = 1'b0;
            out_valid_nx_s = 1'b0;
         end
      endcase
   end

   // Operand capture, per-nibble shifting and result latching.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         a_r     <= {WIDTH{1'b0}};
         b_r     <= {WIDTH{1'b0}};
         acc_r   <= {WIDTH{1'b0}};
         carry_r <= 1'b0;
         idx_r   <= IDX_ZERO;
         sum_r   <= {WIDTH{1'b0}};
         cout_r  <= 1'b0;
      end else begin
         case (state_r)
            ST_IDLE: begin
               if (accept_s) begin
                  a_r     <= bus.a;
                  b_r     <= bus.b;
                  carry_r <= bus.cin;
                  idx_r   <= IDX_ZERO;
               end
            end
            ST_RUN: begin
               a_r     <= a_r >> 3'd4;
               b_r     <= b_r >> 3'd4;
               acc_r   <= acc_nx_s;
               carry_r <= slice_s[4];
               idx_r   <= idx_r + IDX_ONE;
               if (last_s) begin
                  sum_r  <= acc_nx_s;
                  cout_r <= slice_s[4];
               end
            end
            ST_DONE: begin
               sum_r <= sum_r;
            end
            default: begin
               idx_r <= IDX_ZERO;
            end
         endcase
      end
   end

`ifdef OVERFLOW_EN
   // Operand sign capture at accept and signed-overflow flag at the last nibble.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         a_msb_r <= 1'b0;
         b_msb_r <= 1'b0;
         ovf_r   <= 1'b0;
      end else begin
         if (accept_s) begin
            a_msb_r <= bus.a[WIDTH-1];
            b_msb_r <= bus.b[WIDTH-1];
         end
         if ((state_r == ST_RUN) && last_s) begin
            ovf_r <= (a_msb_r == b_msb_r) & (acc_nx_s[WIDTH-1] != a_msb_r);
         end
      end
   end

   assign bus.ovf = ovf_r;
`endif

   assign bus.in_ready  = in_ready_r;
   assign bus.out_valid = out_valid_r;
   assign bus.sum       = sum_r;
   assign bus.cout      = cout_r;

endmodule
